sipo_word_receiver: RTL and testbench

Serial-in/parallel-out receiver forming the far end of the 16-bit shift-register serial link. It samples the serial bit stream produced by the shift-register transmitter, one bit per qualified clock, and reassembles WIDTH-bit words in either bit order. Each completed word is passed to a one-deep output buffer with a valid/ready handshake and sticky overrun detection.

---
 rtl/sipo_word_receiver.sv | 146 ++++++++++++++
 tb/tb_sipo_word_receiver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_word_receiver.sv
// Serial-in/parallel-out word receiver with one-deep output buffer.
// Define SIPO_PARITY_EN to append and check an even-parity bit per frame.
module sipo_word_receiver #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       din,
  input  logic                       bit_valid,
  input  logic                       left,
  input  logic                       clear,
  output logic [WIDTH-1:0]           word,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       overrun,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       parity_err
);

  localparam int CW = $clog2(WIDTH+1);
`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cur;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] sh_nxt;
  logic [WIDTH-1:0] asm_word;
  logic             order;
  logic             ord;
  logic             first;
  logic             last;
  logic             data_bit;
  logic             pop;
  logic             load;
  logic             drop;
`ifdef SIPO_PARITY_EN
  logic             perr_nxt;
`endif

  // Bit decode: frame position, bit order and assembled word
  always_comb begin
    first    = bit_valid && (clear || state == IDLE);
    ord      = first ? left : order;
    cur      = first ? '0 : cnt;
    last     = bit_valid && (cur == CW'(FRAME - 1));
`ifdef SIPO_PARITY_EN
    data_bit = bit_valid && (cur < CW'(WIDTH));
`else
    data_bit = bit_valid;
`endif
    sh_nxt   = sh;
    if (data_bit) begin
      if (ord)
        sh_nxt = {sh[WIDTH-2:0], din};
      else
        sh_nxt = {din, sh[WIDTH-1:1]};
    end
`ifdef SIPO_PARITY_EN
    asm_word = sh;
    perr_nxt = (^sh) ^ din;
`else
    asm_word = sh_nxt;
`endif
    pop      = word_valid && word_ready;
    load     = last && (!word_valid || pop);
    drop     = last && word_valid && !pop;
  end

  // Next state and bit counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (last) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (bit_valid) begin
      state_nxt = SHIFT;
      cnt_nxt   = cur + 1'b1;
    end else if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  // Receive state, counter, shift register and latched order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      order <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sh    <= sh_nxt;
      order <= ord;
    end
  end

  // Output buffer with handshake and sticky overrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word       <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        word       <= asm_word;
        word_valid <= 1'b1;
      end else if (pop) begin
        word_valid <= 1'b0;
      end
      if (clear)
        overrun <= 1'b0;
      else if (drop)
        overrun <= 1'b1;
    end
  end

`ifdef SIPO_PARITY_EN
  // Parity result travels with the buffered word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      parity_err <= 1'b0;
    else if (load)
      parity_err <= perr_nxt;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign bit_count = cnt;

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Scoreboard bench for sipo_word_receiver.
// Expected words queue on send, pop on handshake.
module tb_sipo_word_receiver;

  localparam int W  = 16;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din = 1'b0;
  logic          bit_valid = 1'b0;
  logic          left = 1'b0;
  logic          clear = 1'b0;
  logic [W-1:0]  word;
  logic          word_valid;
  logic          word_ready = 1'b0;
  logic          overrun;
  logic [CW-1:0] bit_count;
  logic          parity_err;

  int checks = 0;
  int failures = 0;
  logic [W:0] exp_q[$];

  sipo_word_receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .bit_valid  (bit_valid),
    .left       (left),
    .clear      (clear),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .bit_count  (bit_count),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {16'd0, word}, 32'hFFFF_FFFF);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        chk("sb_word", {16'd0, word}, {16'd0, e[W-1:0]});
        chk("sb_perr", {31'd0, parity_err}, {31'd0, e[W]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w,
                      input bit msb,
                      input int tog,
                      input bit clr,
                      input int rdy_last,
                      input int pbit,
                      input bit push);
    logic pb;
    logic pe;
    pb = (pbit < 0) ? ^w : pbit[0];
`ifdef SIPO_PARITY_EN
    pe = (^w) ^ pb;
`else
    pe = 1'b0;
`endif
    for (int i = 0; i < W; i++) begin
      if (i == 0) left = msb;
      clear = clr && (i == 0);
      din = msb ? w[W-1-i] : w[i];
      bit_valid = 1'b1;
`ifndef SIPO_PARITY_EN
      if (i == W - 1) begin
        if (rdy_last >= 0) word_ready = rdy_last[0];
        if (push) exp_q.push_back({pe, w});
      end
`endif
      tick();
      if (i == tog) left = ~left;
    end
`ifdef SIPO_PARITY_EN
    clear = 1'b0;
    din = pb;
    if (rdy_last >= 0) word_ready = rdy_last[0];
    if (push) exp_q.push_back({pe, w});
    tick();
`endif
    bit_valid = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_word", {16'd0, word}, 32'd0);
    chk("rst_valid", {31'd0, word_valid}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_cnt", {27'd0, bit_count}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // MSB first, ready high
    word_ready = 1'b1;
    send(16'hA5A5, 1'b1, -1, 1'b0, -1, -1, 1'b1);
    chk("msb_valid", {31'd0, word_valid}, 32'd1);
    chk("msb_word", {16'd0, word}, 32'h0000_A5A5);
    chk("msb_cnt", {27'd0, bit_count}, 32'd0);
    tick();
    chk("msb_drop", {31'd0, word_valid}, 32'd0);

    // LSB first with order change mid-frame
    send(16'hABCD, 1'b0, 5, 1'b0, -1, -1, 1'b1);
    chk("lsb_word", {16'd0, word}, 32'h0000_ABCD);
    tick();

    // backpressure and overrun
    word_ready = 1'b0;
    send(16'h1234, 1'b1, -1, 1'b0, -1, -1, 1'b1);
    tick();
    send(16'h5678, 1'b1, -1, 1'b0, -1, -1, 1'b0);
    chk("ovr_word", {16'd0, word}, 32'h0000_1234);
    chk("ovr_valid", {31'd0, word_valid}, 32'd1);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    word_ready = 1'b1;
    tick();
    chk("ovr_pop", {31'd0, word_valid}, 32'd0);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ovr_clear", {31'd0, overrun}, 32'd0);

    // clear mid-frame, then reset mid-frame
    word_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      din = 1'($urandom_range(1));
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    chk("garb_cnt", {27'd0, bit_count}, 32'd7);
    send(16'hABCD, 1'b1, -1, 1'b1, -1, -1, 1'b0);
    chk("clr_word", {16'd0, word}, 32'h0000_ABCD);
    chk("clr_valid", {31'd0, word_valid}, 32'd1);
    for (int i = 0; i < 9; i++) begin
      din = 1'($urandom_range(1));
      bit_valid = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    chk("pre_rst_cnt", {27'd0, bit_count}, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", {27'd0, bit_count}, 32'd0);
    chk("mid_rst_valid", {31'd0, word_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // completion on the cycle of a pop
    word_ready = 1'b0;
    send(16'h00FF, 1'b1, -1, 1'b0, -1, -1, 1'b1);
    send(16'hFF00, 1'b1, -1, 1'b0, 1, -1, 1'b1);
    chk("sim_word", {16'd0, word}, 32'h0000_FF00);
    chk("sim_valid", {31'd0, word_valid}, 32'd1);
    chk("sim_ovr", {31'd0, overrun}, 32'd0);
    tick();

`ifdef SIPO_PARITY_EN
    // parity checking
    send(16'hA5A5, 1'b1, -1, 1'b0, -1, 0, 1'b1);
    chk("par_ok", {31'd0, parity_err}, 32'd0);
    tick();
    send(16'h0001, 1'b1, -1, 1'b0, -1, 0, 1'b1);
    chk("par_bad", {31'd0, parity_err}, 32'd1);
    tick();
`endif

    word_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
